// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU CRC engine: FSM states, CRC constants
// and the generate/check mode encodings.
package modbus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        APP_LO = 2'd2,
        APP_HI = 2'd3
    } state_e;

    localparam logic [15:0] MODBUS_CRC_POLY = 16'hA001;
    localparam logic [15:0] MODBUS_CRC_INIT = 16'hFFFF;

    localparam logic MODE_CHECK = 1'b0;
    localparam logic MODE_GEN   = 1'b1;

endpackage

// File: rtl/crc16_byte_update.sv
// One-byte step of a reflected (LSB-first) CRC-16: eight shift/xor steps
// unrolled into a single combinational stage.
module crc16_byte_update #(
    parameter logic [15:0] POLY = 16'hA001
) (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/modbus_crc_engine.sv
// Streaming Modbus RTU CRC engine: in generate mode appends the CRC to a frame,
// in check mode passes the frame through and reports whether the residue is zero.
module modbus_crc_engine
    import modbus_pkg::*;
#(
    parameter int          MAX_LEN  = 256,
    parameter logic [15:0] CRC_POLY = MODBUS_CRC_POLY,
    parameter logic [15:0] CRC_INIT = MODBUS_CRC_INIT,
    localparam int         LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_gen,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             done,
    output logic             crc_ok,
    output logic             len_err,
    output logic [LEN_W-1:0] frame_len,
    output logic [15:0]      crc_value
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_e           state;
    logic             mode;
    logic [15:0]      crc;
    logic [LEN_W-1:0] len;
    logic             over;
    logic             hi_sent;

    logic             first;
    logic             frame_mode;
    logic             out_free;
    logic             accept;
    logic [15:0]      crc_base;
    logic [15:0]      crc_next;
    logic [LEN_W-1:0] len_next;
    logic             over_next;
    logic             chk_err;
    logic             gen_err;

    // Handshake: a byte moves on any edge where valid && ready; the single
    // output register may be reloaded in the same cycle it is drained.
    assign out_free   = !m_valid || m_ready;
    assign s_ready    = ((state == IDLE) || (state == DATA)) && out_free;
    assign accept     = s_valid && s_ready;
    assign first      = (state == IDLE);
    assign frame_mode = first ? mode_gen : mode;
    assign crc_base   = first ? CRC_INIT : crc;

    assign len_next  = first ? LEN_W'(1) : ((len == LEN_MAX) ? len : len + 1'b1);
    assign over_next = !first && (over || (len == LEN_MAX));
    assign chk_err   = over_next || (int'(len_next) < 4);
    assign gen_err   = over || (int'(len) > MAX_LEN - 2);

    crc16_byte_update #(.POLY(CRC_POLY)) u_crc (
        .crc_in    (crc_base),
        .data_byte (s_data),
        .crc_out   (crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= MODE_CHECK;
            crc       <= CRC_INIT;
            len       <= '0;
            over      <= 1'b0;
            hi_sent   <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= 8'h00;
            m_last    <= 1'b0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            len_err   <= 1'b0;
            frame_len <= '0;
            crc_value <= 16'h0000;
        end else begin
            done <= 1'b0;
            if (m_valid && m_ready) m_valid <= 1'b0;
            case (state)
                IDLE, DATA: begin
                    if (accept) begin
                        mode    <= frame_mode;
                        crc     <= crc_next;
                        len     <= len_next;
                        over    <= over_next;
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        m_last  <= (frame_mode == MODE_CHECK) && s_last;
                        if (!s_last) begin
                            state <= DATA;
                        end else if (frame_mode == MODE_GEN) begin
                            state <= APP_LO;
                        end else begin
                            state     <= IDLE;
                            done      <= 1'b1;
                            frame_len <= len_next;
                            crc_value <= crc_next;
                            len_err   <= chk_err;
                            crc_ok    <= (crc_next == 16'h0000) && !chk_err;
                        end
                    end
                end
                APP_LO: begin
                    hi_sent <= 1'b0;
                    if (out_free) begin
                        m_data  <= crc[7:0];
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        state   <= APP_HI;
                    end
                end
                APP_HI: begin
                    // First load the high CRC byte, then wait for it to drain.
                    if (!hi_sent) begin
                        if (out_free) begin
                            m_data  <= crc[15:8];
                            m_valid <= 1'b1;
                            m_last  <= 1'b1;
                            hi_sent <= 1'b1;
                        end
                    end else if (m_ready) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        frame_len <= len;
                        crc_value <= crc;
                        len_err   <= gen_err;
                        crc_ok    <= !gen_err;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/modbus_crc_engine.md
MODBUS_CRC_ENGINE -- requirements
Module: modbus_crc_engine

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256: maximum frame length in bytes, CRC bytes included.
REQ-002 SHALL have parameter CRC_POLY, default 16'hA001: reflected CRC-16 polynomial.
REQ-003 SHALL have parameter CRC_INIT, default 16'hFFFF: CRC preset value.
REQ-004 SHALL have localparam LEN_W = clog2(MAX_LEN+1).
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 mode_gen  in  1  1=generate (append CRC), 0=check (verify trailing CRC); sampled on a frame's first accepted byte.
REQ-008 s_data  in  8  input byte.
REQ-009 s_valid  in  1  input byte valid.
REQ-010 s_last  in  1  marks final input byte of frame.
REQ-011 s_ready  out  1  engine accepts input byte.
REQ-012 m_data  out  8  output byte.
REQ-013 m_valid  out  1  output byte valid.
REQ-014 m_last  out  1  marks final output byte of frame.
REQ-015 m_ready  in  1  downstream accepts output byte.
REQ-016 done  out  1  one-cycle pulse: frame result valid.
REQ-017 crc_ok  out  1  check mode: residue zero and no len_err; gen mode: 1 unless len_err.
REQ-018 len_err  out  1  frame length violation.
REQ-019 frame_len  out  LEN_W  bytes accepted on input, saturating at MAX_LEN.
REQ-020 crc_value  out  16  final CRC register value (gen: appended CRC; check: residue).

Function
REQ-021 Transfer on a port SHALL occur when valid && ready are both high on a clk edge.
REQ-022 Output SHALL be a single register stage; s_ready = !m_valid || m_ready, forced 0 in APP_LO/APP_HI.
REQ-023 m_valid SHALL hold with m_data/m_last stable until m_ready.
REQ-024 FSM states SHALL be IDLE, DATA, APP_LO, APP_HI.
  - IDLE->DATA on first accepted byte: latch mode_gen, CRC=update(CRC_INIT, byte), len=1.
  - DATA: each accepted byte updates CRC (LSB-first, 8 shift steps per byte, one byte/cycle) and increments len.
  - A frame SHALL be allowed to consist of a single byte with s_last set.
REQ-025 Check mode: every byte, including the trailing 2 CRC bytes, SHALL pass to m_*, and m_last SHALL copy s_last.
  - On the s_last accept, go to IDLE.
  - crc_ok = (final CRC==0) && !len_err.
REQ-026 Gen mode: data bytes SHALL pass with m_last=0.
  - After the s_last accept, go to APP_LO, emitting CRC[7:0], then APP_HI, emitting CRC[15:8] with m_last=1.
  - Go to IDLE when the APP_HI byte is accepted downstream.
REQ-027 done SHALL pulse exactly 1 cycle.
  - Check: the cycle after the s_last accept.
  - Gen: the cycle after the APP_HI byte is accepted downstream.
  - crc_ok/len_err/frame_len/crc_value SHALL be valid with done and hold until the next done.
REQ-028 len_err SHALL be set when len > MAX_LEN, or in check mode when len < 4, or in gen mode when len > MAX_LEN-2.
  - Bytes beyond MAX_LEN SHALL still pass through; the counter saturates.
REQ-029 A new frame SHALL be accepted the cycle after returning to IDLE; back-to-back frames SHALL need no idle gap in check mode.
REQ-030 mode_gen changes mid-frame SHALL be ignored.
REQ-031 s_valid with s_ready low SHALL not update CRC or len.

Reset
REQ-032 On rst: FSM=IDLE; CRC=CRC_INIT; len=0; m_valid=0; m_data=0; m_last=0; done=0; crc_ok=0; len_err=0; frame_len=0; crc_value=0.
REQ-033 rst mid-frame SHALL abort the frame: partial output is dropped with no done pulse, and s_ready=1 on the first cycle after rst deasserts.

Structure
REQ-034 Package modbus_pkg SHALL hold the state enum, MODBUS_CRC_POLY=16'hA001, MODBUS_CRC_INIT=16'hFFFF and the mode encodings.
REQ-035 Sub-module crc16_byte_update SHALL be purely combinational: crc_in[15:0] and byte[7:0] in, crc_out[15:0] out, POLY parameter.
REQ-036 crc16_byte_update SHALL be reused by the rx/tx framing blocks.

Verification
REQ-037 Gen 01 03 00 00 00 0A, m_ready=1 -> output 01 03 00 00 00 0A C5 CD, m_last on CD, crc_value=16'hCDC5, crc_ok=1, frame_len=6.
REQ-038 Check 01 06 00 01 00 03 98 0B -> passthrough identical, done, crc_ok=1, crc_value=0, frame_len=8; with last byte 0C instead -> crc_ok=0, len_err=0.
REQ-039 Check 3-byte frame 01 83 02 -> done, len_err=1, crc_ok=0.
REQ-040 Gen 6-byte frame with m_ready toggling 1010... -> no byte lost or duplicated, s_ready=0 during append, output identical to REQ-037.
REQ-041 MAX_LEN=8, check 10-byte frame -> all 10 bytes pass, frame_len=8, len_err=1; rst asserted mid-frame -> no done, next frame per REQ-038 passes.
